// File: rtl/counter_ctrl.sv
// Button-driven counter: synchronised, edge-detected buttons queue one request each,
// a round-robin arbiter executes one command at a time, followed by a fixed lockout.
module counter_ctrl #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       btn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             cmd_valid,
    output logic [1:0]       cmd_id,
    output logic             busy,
    output logic             wrap,
    output logic             dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_prev;
    logic [3:0]       r_pending;
    state_t           r_state;
    logic [7:0]       r_hold_cnt;
    logic [1:0]       r_rr;
    logic [WIDTH-1:0] r_count;
    logic             r_cmd_valid;
    logic [1:0]       r_cmd_id;
    logic             r_busy;
    logic             r_wrap;

    logic [3:0]       w_edge;
    logic [2:0]       w_pick;
    logic             w_exec;
    logic [3:0]       w_clr_mask;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;

    // Returns {found, index}; scanning from farthest to nearest lets the nearest win.
    function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] rr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = rr + k[1:0];
            if (pend[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign w_edge     = r_sync2 & ~r_prev;
    assign w_pick     = rr_pick(r_pending, r_rr);
    assign w_exec     = (r_state == S_IDLE) && w_pick[2];
    assign w_clr_mask = w_exec ? (4'b0001 << w_pick[1:0]) : 4'b0000;

    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        case (w_pick[1:0])
            2'd0: begin
                w_next_count = r_count + 1'b1;
                w_next_wrap  = &r_count;
            end
            2'd1: begin
                w_next_count = r_count - 1'b1;
                w_next_wrap  = ~|r_count;
            end
            2'd2:    w_next_count = '0;
            default: w_next_count = din;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            // A fresh edge beats a same-cycle grant clear.
            r_pending <= (r_pending & ~w_clr_mask) | w_edge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_rr        <= 2'd3;
            r_count     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_id    <= 2'd0;
            r_busy      <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_wrap      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_exec) begin
                        r_count     <= w_next_count;
                        r_wrap      <= w_next_wrap;
                        r_cmd_valid <= 1'b1;
                        r_cmd_id    <= w_pick[1:0];
                        r_rr        <= w_pick[1:0];
                        r_hold_cnt  <= HOLD_M1;
                        r_busy      <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign count     = r_count;
    assign cmd_valid = r_cmd_valid;
    assign cmd_id    = r_cmd_id;
    assign busy      = r_busy;
    assign wrap      = r_wrap;
    assign dbg_state = (r_state == S_HOLD);

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width in bits; legal range 2..32.
REQ-002 Parameter HOLD, default 4, SHALL set the lockout length in clock cycles after each executed command; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 btn  input  4  SHALL carry raw, asynchronous, level button inputs: [0]=inc, [1]=dec, [2]=clear, [3]=load.
REQ-006 din  input  WIDTH  SHALL be the load value, sampled in the cycle the load command executes.
REQ-007 count  output  WIDTH  SHALL be the registered counter value.
REQ-008 cmd_valid  output  1  SHALL pulse high for one cycle per executed command.
REQ-009 cmd_id  output  2  SHALL give the index of the executed command; valid only while cmd_valid=1.
REQ-010 busy  output  1  SHALL be high during lockout (state HOLD).
REQ-011 wrap  output  1  SHALL pulse high for one cycle when inc or dec wraps count.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer followed by a third "prev" flop; edge[i] = sync2[i] & ~prev[i].
REQ-013 edge[i] SHALL set pending[i] on the next rising edge; a held button SHALL produce exactly one edge per low-to-high transition.
REQ-014 An edge on a button whose pending bit is already set SHALL be absorbed (no queueing beyond one per button).
REQ-015 The FSM SHALL have two states: IDLE and HOLD.
REQ-016 In IDLE with any pending bit set, on the next edge the arbiter SHALL grant index g, execute it, clear pending[g], register cmd_valid=1 and cmd_id=g, and enter HOLD with the hold counter loaded with HOLD-1.
REQ-017 Arbitration SHALL be round-robin: the search starts at (rr+1) mod 4 and proceeds upward; rr SHALL update to g on each grant.
REQ-018 Command effects: inc: count+1 mod 2^WIDTH; dec: count-1 mod 2^WIDTH; clear: 0; load: din.
REQ-019 wrap SHALL be set for inc from all-ones to 0 and for dec from 0 to all-ones; clear and load SHALL never set wrap.
REQ-020 In HOLD the hold counter SHALL decrement each cycle; when it equals 0 the FSM SHALL return to IDLE on the next edge, giving busy=1 for exactly HOLD cycles.
REQ-021 Pending bits SHALL continue to set during HOLD; they are served after returning to IDLE. The minimum command spacing SHALL be HOLD+1 cycles.
REQ-022 If pending[g] is cleared by a grant in the same cycle edge[g] is high, the set SHALL win and pending[g] SHALL remain 1.
REQ-023 Latency: with btn[i] rising and meeting setup before edge E1, pending[i] SHALL set at E3, and in IDLE count SHALL update with cmd_valid=1 at E4.
REQ-024 count SHALL change only on executed commands.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force: count=0, cmd_valid=0, cmd_id=0, busy=0, wrap=0, state=IDLE, pending=0, sync/prev flops=0, hold counter=0, rr=3 (index 0 wins first).
REQ-026 Reset asserted mid-HOLD or with requests pending SHALL discard all of them; after release, a button already held high SHALL produce one edge and one command.
REQ-027 Release of rst_n SHALL be synchronous to clk externally; the block SHALL need no other init.

Verification
REQ-028 WIDTH=8, HOLD=4: btn[0] rises once -> count 0->1 at E4, cmd_valid=1 and cmd_id=0 for one cycle, then busy=1 for 4 cycles.
REQ-029 Hold btn[0] high for 100 cycles -> exactly one increment.
REQ-030 count=8'hFF, press inc -> count=8'h00 with wrap=1 for one cycle; then press dec -> 8'hFF with wrap=1.
REQ-031 All four btn rise in the same cycle with din=8'h5A from count=0 -> commands executed in order 0,1,2,3 spaced 5 cycles apart; final count=8'h5A.
REQ-032 Press btn[2] twice during HOLD -> exactly one clear executes after HOLD.
REQ-033 Assert rst_n low during HOLD with btn[1] pending -> all outputs go to zero immediately; no dec executes after release.
